inst_fetch_unit: RTL and testbench
==================================

# inst_fetch_unit

Instruction-fetch stage of the RISC-V pipeline: owns the program counter, issues word requests to instruction memory over a valid/ready request channel, and collects in-order responses in a small FIFO. It presents `if_pc`/`if_inst` to the IF/ID pipeline register. It honours back-pressure (`stall`) from ID and PC redirects from branch/jump resolution. Fetches already in flight when a redirect arrives are discarded.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `FIFO_DEPTH`, default 2: instruction buffer entries. Also the cap on outstanding plus buffered fetches; must be ≥ 2.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `imem_req_valid` out 1: fetch request valid.
- `imem_req_ready` in 1: memory accepts the request this cycle.
- `imem_req_addr` out 32: word-aligned fetch address; bits [1:0] are always 0.
- `imem_rsp_valid` in 1: response valid. Responses return in order, at least 1 cycle after acceptance.
- `imem_rsp_data` in 32: instruction word.
- `redirect_valid` in 1: single-cycle pulse to redirect fetch.
- `redirect_pc` in 32: new PC. Bits [1:0] are forced to 0.
- `stall` in 1: ID cannot accept; hold the current output.
- `if_valid` out 1: `if_pc`/`if_inst` are a real fetched instruction.
- `if_pc` out 32: PC of the presented instruction.
- `if_inst` out 32: presented instruction. Reads NOP (32'h0000_0013) when `if_valid`=0.

## Operation
- State:
  - `pc`: next address to request.
  - `outstanding`: accepted requests not yet answered, 0..FIFO_DEPTH.
  - `drop_cnt`: in-flight responses still to discard.
  - FIFO of {pc, inst} pairs.
  - Tag FIFO of issued PCs, so each response is paired with its address.
- `pop` = `if_valid` & !`stall` & !`redirect_valid`.
- `credit` = FIFO_DEPTH − fifo_count − outstanding + pop.
- Issue: `imem_req_valid` = !`rst` & !`redirect_valid` & (`credit` > 0).
  - `imem_req_addr` = `pc`.
  - On accept (valid & ready): `pc` += 4 (mod 2^32, wraps at 32'hFFFF_FFFC to 0), `outstanding`++, and the PC is pushed to the tag FIFO.
- Response: `outstanding`-- and the tag FIFO is popped.
  - If `drop_cnt` > 0 or `redirect_valid`: the data is discarded; `drop_cnt`-- if it was > 0.
  - Otherwise {tag, data} is pushed to the FIFO.
  - The FIFO never overflows, because `credit` reserves a slot for every outstanding fetch.
- Output is taken combinationally from the FIFO head: `if_valid` = !empty & !`redirect_valid`, with `if_pc`/`if_inst` = head.
  - When empty or redirecting: `if_valid`=0, `if_pc`=0, `if_inst`=NOP.
- Stall: the head is held; no pop.
- Redirect (priority over stall, issue and response push):
  - FIFO flushed.
  - `pc` ← {`redirect_pc`[31:2], 2'b00}.
  - `drop_cnt` ← `outstanding` − (`imem_rsp_valid` ? 1 : 0); every fetch that is in flight after this cycle is discarded.
  - No request is issued in the redirect cycle.
- Redirect while `drop_cnt` > 0: `drop_cnt` is recomputed by the same rule, since `outstanding` already covers all in-flight fetches.
- Issue and response in the same cycle: `outstanding` is unchanged.

## Timing
- Reset: `pc`=RESET_PC, FIFO empty, `outstanding`=0, `drop_cnt`=0.
  - Outputs during reset: `imem_req_valid`=0, `if_valid`=0, `if_pc`=0, `if_inst`=NOP.
  - Reset mid-operation abandons all in-flight fetches. Memory responses arriving after reset deasserts for pre-reset requests are outside this contract; the memory is reset together with this block.
- First request: the first cycle with `rst`=0.
- Latency: request accepted in cycle N, response in cycle N+L, instruction presented (`if_valid`=1) in cycle N+L+1.
- Throughput: sustains 1 instruction/cycle with L=1 and FIFO_DEPTH ≥ 2. Larger L needs FIFO_DEPTH ≥ L+1 for full rate.
- Redirect in cycle R:
  - `if_valid`=0 in R.
  - Request to the new PC in R+1, provided `credit` > 0.
  - With L=1, the first new instruction is presented at R+3.
- A stall held for any number of cycles keeps `if_pc`/`if_inst` stable. Requests continue until `credit`=0.

## Test plan
- Reset release, RESET_PC=0, L=1 memory, `stall`=0 → requests at 0,4,8,…; `if_valid` rises 2 cycles after the first request, then 1 instr/cycle with PCs 0,4,8 in order.
- `stall` high for 5 cycles while `if_pc`=8 → outputs stay PC=8 with the same instruction; `imem_req_valid` drops once `credit`=0; stream resumes at 12 with no loss or duplication.
- `redirect_valid` with `redirect_pc`=32'h100 while 1 fetch is outstanding and 2 are buffered → FIFO flushed, the late response is discarded, next request addr=32'h100, and the first presented PC is 32'h100.
- `redirect_pc`=32'h203 → request address 32'h200.
- `imem_req_ready` toggling 1/0 and variable L in 1..3 (FIFO_DEPTH=4) → instruction/PC pairing matches the memory image for 1000 fetches; FIFO never overflows.
- Redirect arriving in the same cycle as a response and with `stall` high → response dropped, `if_valid`=0 that cycle, and fetch restarts at the redirect PC next cycle.

Source files
------------

// File: rtl/inst_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_unit
// Purpose  : RISC-V instruction-fetch stage. This block owns the PC and issues
//            word fetches over a valid/ready request channel. It pairs each
//            in-order response with its issuing PC through a tag FIFO, then
//            buffers {pc, inst} for the IF/ID register. It also handles ID
//            back-pressure and branch/jump redirects.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   imem_req_valid/ready/addr fetch request channel (word aligned address)
//   imem_rsp_valid/data       in-order fetch responses
//   redirect_valid/pc         single-cycle PC redirect
//   stall                     ID cannot accept the presented instruction
//   if_valid/if_pc/if_inst    instruction presented to IF/ID (NOP when idle)
// ============================================================================
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst
);

  localparam logic [31:0]     c_NOP   = 32'h0000_0013;
  localparam int              c_CW    = $clog2(FIFO_DEPTH + 1);
  localparam int              c_AW    = $clog2(FIFO_DEPTH);
  localparam logic [c_CW:0]   c_DEPTH = (c_CW + 1)'(FIFO_DEPTH);
  localparam logic [c_CW-1:0] c_ONE   = c_CW'(1);
  localparam logic [c_AW-1:0] c_LAST  = c_AW'(FIFO_DEPTH - 1);

  // Architectural state
  logic [31:0]     r_pc;
  logic [c_CW-1:0] r_outstanding;
  logic [c_CW-1:0] r_drop_cnt;
  logic [c_CW-1:0] r_count;

  // Instruction buffer
  logic [31:0]     r_buf_pc   [FIFO_DEPTH];
  logic [31:0]     r_buf_inst [FIFO_DEPTH];
  logic [c_AW-1:0] r_buf_wr;
  logic [c_AW-1:0] r_buf_rd;

  // Tag FIFO of issued PCs. Its occupancy equals r_outstanding, which
  // never exceeds FIFO_DEPTH, so no separate count is kept.
  logic [31:0]     r_tag [FIFO_DEPTH];
  logic [c_AW-1:0] r_tag_wr;
  logic [c_AW-1:0] r_tag_rd;

  logic            w_empty;
  logic            w_pop;
  logic            w_accept;
  logic            w_push;
  logic            w_can_issue;
  logic [c_CW:0]   w_used;
  logic [c_CW:0]   w_limit;

  function automatic logic [c_AW-1:0] f_next(input logic [c_AW-1:0] p);
    return (p == c_LAST) ? '0 : p + c_AW'(1);
  endfunction

  // Output comes straight from the buffer head. A redirect hides the head
  // in the same cycle because that entry is about to be flushed.
  assign w_empty  = (r_count == '0);
  assign if_valid = !rst && !w_empty && !redirect_valid;
  assign if_pc    = if_valid ? r_buf_pc[r_buf_rd]   : 32'h0;
  assign if_inst  = if_valid ? r_buf_inst[r_buf_rd] : c_NOP;
  assign w_pop    = if_valid && !stall;

  // Credit check: buffered + outstanding must stay below the depth. The
  // slot freed by a same-cycle pop counts, which allows 1 instr/cycle
  // with the minimum depth.
  assign w_used      = {1'b0, r_count} + {1'b0, r_outstanding};
  assign w_limit     = c_DEPTH + {{c_CW{1'b0}}, w_pop};
  assign w_can_issue = (w_used < w_limit);

  assign imem_req_valid = !rst && !redirect_valid && w_can_issue;
  assign imem_req_addr  = r_pc;
  assign w_accept       = imem_req_valid && imem_req_ready;

  // Responses to fetches older than the last redirect are discarded, as is
  // a response landing in the redirect cycle itself.
  assign w_push = imem_rsp_valid && (r_drop_cnt == '0) && !redirect_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc          <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
      r_count       <= '0;
      r_buf_wr      <= '0;
      r_buf_rd      <= '0;
      r_tag_wr      <= '0;
      r_tag_rd      <= '0;
    end else begin
      // The tag FIFO tracks every in-flight fetch, including the ones that
      // will be discarded, so it is not flushed on redirect.
      if (w_accept) begin
        r_tag[r_tag_wr] <= r_pc;
        r_tag_wr        <= f_next(r_tag_wr);
      end
      if (imem_rsp_valid) begin
        r_tag_rd <= f_next(r_tag_rd);
      end

      if (w_accept && !imem_rsp_valid) begin
        r_outstanding <= r_outstanding + c_ONE;
      end else if (!w_accept && imem_rsp_valid) begin
        r_outstanding <= r_outstanding - c_ONE;
      end

      if (redirect_valid) begin
        r_pc       <= {redirect_pc[31:2], 2'b00};
        // Every fetch still in flight after this cycle belongs to the old
        // stream. This also covers a redirect that arrives while an
        // earlier drop is still pending.
        r_drop_cnt <= r_outstanding - (imem_rsp_valid ? c_ONE : '0);
        r_count    <= '0;
        r_buf_wr   <= '0;
        r_buf_rd   <= '0;
      end else begin
        if (w_accept) begin
          r_pc <= r_pc + 32'd4;
        end
        if (imem_rsp_valid && (r_drop_cnt != '0)) begin
          r_drop_cnt <= r_drop_cnt - c_ONE;
        end
        if (w_push) begin
          r_buf_pc[r_buf_wr]   <= r_tag[r_tag_rd];
          r_buf_inst[r_buf_wr] <= imem_rsp_data;
          r_buf_wr             <= f_next(r_buf_wr);
        end
        if (w_pop) begin
          r_buf_rd <= f_next(r_buf_rd);
        end
        if (w_push && !w_pop) begin
          r_count <= r_count + c_ONE;
        end else if (!w_push && w_pop) begin
          r_count <= r_count - c_ONE;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_fetch_unit
// Purpose  : Self-checking bench for inst_fetch_unit (FIFO_DEPTH=4) with an
//            in-order instruction memory model of configurable latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_fetch_unit;

  localparam logic [31:0] c_NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;

  always #5 clk = ~clk;

  inst_fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (4)
  ) u_dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_inst        (if_inst)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  // Memory image
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // In-order memory model: accepted addresses with their due cycle
  logic [31:0] q_addr[$];
  int          q_due[$];
  int          cyc     = 0;
  int          mem_lat = 1;

  // Snapshot of DUT outputs for the current cycle
  logic        s_req_valid;
  logic [31:0] s_req_addr;
  logic        s_if_valid;
  logic [31:0] s_if_pc;
  logic [31:0] s_if_inst;

  // One clock cycle: drive the memory response, sample outputs, record an
  // accepted request, then advance past the next rising edge.
  task automatic tick();
    if (rst) begin
      q_addr.delete();
      q_due.delete();
    end
    if (!rst && q_due.size() > 0 && q_due[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(q_addr[0]);
      q_addr.delete(0);
      q_due.delete(0);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'hDEAD_BEEF;
    end
    #1;
    s_req_valid = imem_req_valid;
    s_req_addr  = imem_req_addr;
    s_if_valid  = if_valid;
    s_if_pc     = if_pc;
    s_if_inst   = if_inst;
    if (imem_req_valid && imem_req_ready) begin
      q_addr.push_back(imem_req_addr);
      q_due.push_back(cyc + mem_lat);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    stall          = 1'b0;
    imem_req_ready = 1'b1;
    mem_lat        = 1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  logic [31:0] exp_pc;
  int          consumed;
  int          guard;
  logic        stall_req_exp [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    rst            = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    @(posedge clk);
    #1;

    // ---------------- Reset state and basic streaming ----------------
    do_reset();
    check("rst_req_valid", {31'b0, s_req_valid}, 32'd0);
    check("rst_if_valid",  {31'b0, s_if_valid},  32'd0);
    check("rst_if_pc",     s_if_pc,              32'h0);
    check("rst_if_inst",   s_if_inst,            c_NOP);

    tick(); // c0
    check("c0_req_valid", {31'b0, s_req_valid}, 32'd1);
    check("c0_req_addr",  s_req_addr,           32'h0);
    check("c0_if_valid",  {31'b0, s_if_valid},  32'd0);
    tick(); // c1
    check("c1_req_addr",  s_req_addr,           32'h4);
    check("c1_if_valid",  {31'b0, s_if_valid},  32'd0);
    tick(); // c2
    check("c2_if_valid",  {31'b0, s_if_valid},  32'd1);
    check("c2_if_pc",     s_if_pc,              32'h0);
    check("c2_if_inst",   s_if_inst,            mem_word(32'h0));
    check("c2_req_addr",  s_req_addr,           32'h8);
    tick(); // c3
    check("c3_if_pc",     s_if_pc,              32'h4);

    // ---------------- Stall for 5 cycles at PC 8 ----------------
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_if_valid",  {31'b0, s_if_valid},  32'd1);
      check("stall_if_pc",     s_if_pc,              32'h8);
      check("stall_if_inst",   s_if_inst,            mem_word(32'h8));
      check("stall_req_valid", {31'b0, s_req_valid}, {31'b0, stall_req_exp[i]});
    end
    stall = 1'b0;
    tick(); // c9
    check("resume_if_pc",    s_if_pc,              32'h8);
    check("resume_req_valid", {31'b0, s_req_valid}, 32'd1);
    check("resume_req_addr", s_req_addr,           32'h18);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("resume_seq_pc",   s_if_pc,   32'hC + 32'(4 * i));
      check("resume_seq_inst", s_if_inst, mem_word(32'hC + 32'(4 * i)));
    end

    // ---------------- Redirect with 1 outstanding, 2 buffered ----------------
    do_reset();
    repeat (4) tick(); // c0..c3
    mem_lat = 2;       // fetch of 0x10 returns late
    stall   = 1'b1;
    tick();            // c4
    check("pre_redir_if_pc", s_if_pc,    32'h8);
    check("pre_redir_req",   s_req_addr, 32'h10);
    mem_lat        = 1;
    stall          = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    tick();            // c5
    check("redir_if_valid",  {31'b0, s_if_valid},  32'd0);
    check("redir_req_valid", {31'b0, s_req_valid}, 32'd0);
    check("redir_if_inst",   s_if_inst,            c_NOP);
    redirect_valid = 1'b0;
    tick();            // c6: late response discarded, new request
    check("redir1_req_valid", {31'b0, s_req_valid}, 32'd1);
    check("redir1_req_addr",  s_req_addr,           32'h100);
    check("redir1_if_valid",  {31'b0, s_if_valid},  32'd0);
    tick();            // c7
    check("redir2_if_valid",  {31'b0, s_if_valid},  32'd0);
    tick();            // c8
    check("redir3_if_valid",  {31'b0, s_if_valid},  32'd1);
    check("redir3_if_pc",     s_if_pc,              32'h100);
    check("redir3_if_inst",   s_if_inst,            mem_word(32'h100));

    // ---------------- Redirect + response + stall, unaligned target ----------------
    redirect_valid = 1'b1;
    redirect_pc    = 32'h203;
    stall          = 1'b1;
    tick();            // c9 (response for 0x108 arrives here)
    check("rsr_rsp_seen",    {31'b0, imem_rsp_valid}, 32'd1);
    check("rsr_if_valid",    {31'b0, s_if_valid},     32'd0);
    check("rsr_req_valid",   {31'b0, s_req_valid},    32'd0);
    redirect_valid = 1'b0;
    stall          = 1'b0;
    tick();            // c10
    check("rsr1_req_valid",  {31'b0, s_req_valid},    32'd1);
    check("rsr1_req_addr",   s_req_addr,              32'h200);
    check("rsr1_if_valid",   {31'b0, s_if_valid},     32'd0);
    tick();            // c11
    check("rsr2_if_valid",   {31'b0, s_if_valid},     32'd0);
    tick();            // c12
    check("rsr3_if_pc",      s_if_pc,                 32'h200);
    check("rsr3_if_inst",    s_if_inst,               mem_word(32'h200));

    // ---------------- Random ready/latency/stall/redirect, 1000 fetches ----------------
    do_reset();
    exp_pc   = 32'h0;
    consumed = 0;
    guard    = 0;
    while (consumed < 1000 && guard < 20000) begin
      imem_req_ready = 1'($urandom_range(0, 1));
      mem_lat        = int'($urandom_range(1, 3));
      stall          = ($urandom_range(0, 3) == 0);
      redirect_valid = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 1) == 0) redirect_pc = $urandom;
      else redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      tick();
      guard++;
      if (redirect_valid) begin
        check("rand_redir_if_valid", {31'b0, s_if_valid}, 32'd0);
        exp_pc = {redirect_pc[31:2], 2'b00};
      end else if (s_if_valid && !stall) begin
        check("rand_pc",   s_if_pc,   exp_pc);
        check("rand_inst", s_if_inst, mem_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
        consumed++;
      end
    end
    check("rand_fetch_count", 32'(consumed), 32'd1000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
